// File: rtl/serial_subtractor_if.sv
// Handshake bundle for serial_subtractor: operand request side and result side.
// The master drives operands and result-ready; the slave (the subtractor) answers.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic             io_in_bin;
  logic [WIDTH-1:0] io_in_lhs;
  logic [WIDTH-1:0] io_in_rhs;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_diff;
  logic             io_out_bout;

  modport master (
    output io_in_valid, io_in_bin, io_in_lhs, io_in_rhs, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_diff, io_out_bout
  );

  modport slave (
    input  io_in_valid, io_in_bin, io_in_lhs, io_in_rhs, io_out_ready,
    output io_in_ready, io_out_valid, io_out_diff, io_out_bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: lhs - rhs - bin resolved LSB first, one bit per cycle,
// through a single borrow flop; result and borrow-out held until consumed.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lhs_q, lhs_d;
  logic [WIDTH-1:0] rhs_q, rhs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             bit_a, bit_b, bit_d;
  logic             last_bit;

  assign bit_a    = lhs_q[0];
  assign bit_b    = rhs_q[0];
  assign bit_d    = bit_a ^ bit_b ^ br_q;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      res_q   <= res_d;
      br_q    <= br_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.io_in_valid) state_d = BUSY;
      BUSY:    if (last_bit) state_d = DONE;
      DONE:    if (bus.io_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, then shift operands right and result in from the MSB.
  always_comb begin
    cnt_d = cnt_q;
    lhs_d = lhs_q;
    rhs_d = rhs_q;
    res_d = res_q;
    br_d  = br_q;
    case (state_q)
      IDLE: begin
        if (bus.io_in_valid) begin
          lhs_d = bus.io_in_lhs;
          rhs_d = bus.io_in_rhs;
          br_d  = bus.io_in_bin;
          cnt_d = '0;
        end
      end
      BUSY: begin
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = bit_d;
        lhs_d            = lhs_q >> 1;
        rhs_d            = rhs_q >> 1;
        br_d             = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        cnt_d            = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.io_in_ready  = (state_q == IDLE);
    bus.io_out_valid = (state_q == DONE);
    bus.io_out_diff  = res_q;
    bus.io_out_bout  = br_q;
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH 8, 2 and 1 with a result scoreboard
// and an adder round-trip check at WIDTH 2.
module tb_serial_subtractor;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [32:0] sb8[$];
  logic [32:0] sb2[$];
  logic [32:0] sb1[$];

  serial_subtractor_if #(.WIDTH(8)) b8();
  serial_subtractor_if #(.WIDTH(2)) b2();
  serial_subtractor_if #(.WIDTH(1)) b1();

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(b8.slave));
  serial_subtractor #(.WIDTH(2)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: modular difference in the low bits, borrow as an unsigned compare.
  function automatic logic [32:0] model(input int l, input int r, input int bn, input int w);
    logic [31:0] diff;
    logic        bout;
    diff = 32'((l - r - bn) & ((1 << w) - 1));
    bout = (l < r + bn);
    return {bout, diff};
  endfunction

  task automatic run8(input int l, input int r, input int bn, input string tag);
    int          k;
    logic [32:0] exp;
    check({tag, "_in_ready"}, 32'(b8.io_in_ready), 32'd1);
    b8.io_in_valid  = 1'b1;
    b8.io_in_lhs    = 8'(l);
    b8.io_in_rhs    = 8'(r);
    b8.io_in_bin    = 1'(bn);
    b8.io_out_ready = 1'b1;
    sb8.push_back(model(l, r, bn, 8));
    tick();
    b8.io_in_valid = 1'b0;
    k = 1;
    while (!b8.io_out_valid && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd9);
    check({tag, "_sb_pending"}, 32'(sb8.size()), 32'd1);
    exp = (sb8.size() > 0) ? sb8.pop_front() : 33'h0;
    check({tag, "_diff"}, 32'(b8.io_out_diff), exp[31:0]);
    check({tag, "_bout"}, 32'(b8.io_out_bout), 32'(exp[32]));
    tick();
    check({tag, "_valid_drop"}, 32'(b8.io_out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(b8.io_in_ready), 32'd1);
  endtask

  task automatic run2(input int l, input int r, input int bn);
    int          k;
    logic [32:0] exp;
    logic [2:0]  sum;
    check("w2_in_ready", 32'(b2.io_in_ready), 32'd1);
    b2.io_in_valid = 1'b1;
    b2.io_in_lhs   = 2'(l);
    b2.io_in_rhs   = 2'(r);
    b2.io_in_bin   = 1'(bn);
    sb2.push_back(model(l, r, bn, 2));
    tick();
    b2.io_in_valid = 1'b0;
    k = 1;
    while (!b2.io_out_valid && k < 20) begin
      tick();
      k++;
    end
    check("w2_latency", 32'(k), 32'd3);
    exp = (sb2.size() > 0) ? sb2.pop_front() : 33'h0;
    check("w2_diff", 32'(b2.io_out_diff), exp[31:0]);
    check("w2_bout", 32'(b2.io_out_bout), 32'(exp[32]));
    sum = {1'b0, b2.io_out_diff} + 3'(r) + 3'(bn);
    check("w2_adder_sum", 32'(sum[1:0]), 32'(l));
    check("w2_adder_cout", 32'(sum[2]), 32'(b2.io_out_bout));
    tick();
  endtask

  task automatic run1(input int l, input int r, input int bn);
    int          k;
    logic [32:0] exp;
    check("w1_in_ready", 32'(b1.io_in_ready), 32'd1);
    b1.io_in_valid = 1'b1;
    b1.io_in_lhs   = 1'(l);
    b1.io_in_rhs   = 1'(r);
    b1.io_in_bin   = 1'(bn);
    sb1.push_back(model(l, r, bn, 1));
    tick();
    b1.io_in_valid = 1'b0;
    k = 1;
    while (!b1.io_out_valid && k < 20) begin
      tick();
      k++;
    end
    check("w1_latency", 32'(k), 32'd2);
    exp = (sb1.size() > 0) ? sb1.pop_front() : 33'h0;
    check("w1_diff", 32'(b1.io_out_diff), exp[31:0]);
    check("w1_bout", 32'(b1.io_out_bout), 32'(exp[32]));
    tick();
  endtask

  initial begin
    int          k;
    logic        seen;
    logic [32:0] exp;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    b8.io_in_valid = 1'b0; b8.io_in_bin = 1'b0; b8.io_in_lhs = '0; b8.io_in_rhs = '0;
    b8.io_out_ready = 1'b1;
    b2.io_in_valid = 1'b0; b2.io_in_bin = 1'b0; b2.io_in_lhs = '0; b2.io_in_rhs = '0;
    b2.io_out_ready = 1'b1;
    b1.io_in_valid = 1'b0; b1.io_in_bin = 1'b0; b1.io_in_lhs = '0; b1.io_in_rhs = '0;
    b1.io_out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_in_ready", 32'(b8.io_in_ready), 32'd1);
    check("rst_out_valid", 32'(b8.io_out_valid), 32'd0);
    check("rst_diff", 32'(b8.io_out_diff), 32'd0);
    check("rst_bout", 32'(b8.io_out_bout), 32'd0);

    run8(8'h5A, 8'h23, 0, "basic");
    run8(8'h00, 8'h01, 1, "wrap");
    run8(8'h10, 8'h10, 0, "equal");
    run8(8'h10, 8'h10, 1, "equal_bin");
    run8(8'hFF, 8'h00, 1, "max");

    // Backpressure: result must hold while a competing operand set is offered.
    b8.io_out_ready = 1'b0;
    check("bp_in_ready", 32'(b8.io_in_ready), 32'd1);
    b8.io_in_valid = 1'b1;
    b8.io_in_lhs   = 8'hC3;
    b8.io_in_rhs   = 8'h5A;
    b8.io_in_bin   = 1'b1;
    sb8.push_back(model(8'hC3, 8'h5A, 1, 8));
    tick();
    b8.io_in_valid = 1'b0;
    k = 1;
    while (!b8.io_out_valid && k < 40) begin
      tick();
      k++;
    end
    check("bp_latency", 32'(k), 32'd9);
    exp = (sb8.size() > 0) ? sb8.pop_front() : 33'h0;
    check("bp_diff", 32'(b8.io_out_diff), exp[31:0]);
    check("bp_bout", 32'(b8.io_out_bout), 32'(exp[32]));
    b8.io_in_valid = 1'b1;
    b8.io_in_lhs   = 8'h11;
    b8.io_in_rhs   = 8'h22;
    b8.io_in_bin   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(b8.io_out_valid), 32'd1);
      check("bp_hold_diff", 32'(b8.io_out_diff), exp[31:0]);
      check("bp_hold_bout", 32'(b8.io_out_bout), 32'(exp[32]));
      check("bp_hold_in_ready", 32'(b8.io_in_ready), 32'd0);
    end
    b8.io_in_valid  = 1'b0;
    b8.io_out_ready = 1'b1;
    tick();
    check("bp_release_ready", 32'(b8.io_in_ready), 32'd1);
    check("bp_release_valid", 32'(b8.io_out_valid), 32'd0);
    check("bp_diff_retained", 32'(b8.io_out_diff), exp[31:0]);

    // Reset three cycles into a transaction abandons it.
    b8.io_in_valid = 1'b1;
    b8.io_in_lhs   = 8'h9C;
    b8.io_in_rhs   = 8'h21;
    b8.io_in_bin   = 1'b0;
    sb8.push_back(model(8'h9C, 8'h21, 0, 8));
    tick();
    b8.io_in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb8.delete();
    check("mid_rst_in_ready", 32'(b8.io_in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(b8.io_out_valid), 32'd0);
    check("mid_rst_diff", 32'(b8.io_out_diff), 32'd0);
    check("mid_rst_bout", 32'(b8.io_out_bout), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (b8.io_out_valid) seen = 1'b1;
    end
    check("mid_rst_no_pulse", 32'(seen), 32'd0);
    run8(8'h33, 8'h44, 0, "post_rst");

    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 4; r++)
        for (int bn = 0; bn < 2; bn++)
          run2(l, r, bn);

    run1(0, 1, 0);
    for (int l = 0; l < 2; l++)
      for (int r = 0; r < 2; r++)
        for (int bn = 0; bn < 2; bn++)
          run1(l, r, bn);

    check("sb8_drained", 32'(sb8.size()), 32'd0);
    check("sb2_drained", 32'(sb2.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
